alif_drive_ctrl: RTL
====================

Name: alif_drive_ctrl

Overview:
Sequential, parametrised successor to the combinational car-computer guard. It adds the following:
- Temperature hysteresis on the shut-off output.
- A debounced `arrived` input.
- A fuel-threshold compare.
- A 4-state trip FSM that drives `keep_driving` from a register.
It sits between the sensor front-end and the vehicle/computer power control.

Parameters:
- TEMP_W, 8, width of `cpu_temp`.
- TEMP_HI, 90, shut-off threshold (inclusive, `>=`).
- TEMP_LO, 75, restore threshold (inclusive, `<=`). Legal only if TEMP_LO < TEMP_HI.
- FUEL_W, 8, width of `fuel_level`.
- FUEL_MIN, 4, tank is empty when `fuel_level < FUEL_MIN`.
- HOLD_CYC, 3, consecutive sampled cycles `arrived` must be high. Must be >= 1; 1 means no debounce.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to begin a trip.
- arrived, input, 1, raw destination-reached indication.
- cpu_temp, input, TEMP_W, unsigned CPU temperature.
- fuel_level, input, FUEL_W, unsigned fuel level.
- shut_off_computer, output, 1, registered; hysteretic overheat flag.
- keep_driving, output, 1, registered; 1 only in state DRIVE.
- state, output, 2, current FSM state encoding.
- overheat_cnt, output, 8, present only with ALIF_OVERHEAT_CNT_EN.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-trip):
  - state=IDLE(2'd0), shut_off_computer=0, keep_driving=0.
  - Debounce counter=0, overheat_cnt=0.
- Shut-off (independent of FSM, evaluated every edge):
  - `cpu_temp>=TEMP_HI` → 1.
  - Else `cpu_temp<=TEMP_LO` → 0.
  - Else hold.
  - Latency is 1 edge.
- Debounce:
  - `arr_cnt` is `$clog2(HOLD_CYC+1)` bits wide.
  - `arrived=0` clears it.
  - `arrived=1` increments it, saturating at HOLD_CYC-1.
  - `arr_det = arrived && arr_cnt==HOLD_CYC-1` (combinational), so it is true on the HOLD_CYC-th consecutive high sample.
  - A single low sample restarts the count.
- Empty flag: `empty = fuel_level < FUEL_MIN` (combinational, unsigned compare).
- FSM states: IDLE=0, DRIVE=1, ARRIVED=2, STALLED=3. All transitions happen on a clk edge.
  - IDLE: `start && !empty` → DRIVE. `start && empty` → STALLED. Otherwise stay.
  - DRIVE: `arr_det` → ARRIVED. Else `empty` → STALLED. Arrival has priority when both are true in the same cycle.
  - ARRIVED: raw `arrived=0` → IDLE. `start` is ignored.
  - STALLED: `!empty` → IDLE. Refuelling never resumes driving without a new `start`.
- keep_driving: registered, equals `(next_state==DRIVE)`, so it matches `state==DRIVE` in the same cycle.
- Overheat does not alter the FSM; the car keeps driving while the computer is shut off.
- `start` asserted while in DRIVE, ARRIVED or STALLED has no effect.
- Held-high `start` in IDLE behaves identically to a pulse.

Optional Feature:
- Macro: ALIF_OVERHEAT_CNT_EN.
- When defined:
  - Port `overheat_cnt[7:0]` exists.
  - It increments by 1 on each 0→1 transition of `shut_off_computer` (registered, same edge the flag sets).
  - It saturates at 255 with no wrap.
  - It resets to 0.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset and start: release rst_n with fuel_level=50, pulse start one cycle → state=1 and keep_driving=1 after that edge. Assert rst_n=0 mid-DRIVE → state=0 and keep_driving=0 immediately, without waiting for a clock edge.
2. Debounce: in DRIVE, arrived pattern 1,1,0,1,1,1 over six edges → remains DRIVE through edge 5, state=2 after edge 6, keep_driving=0. Then arrived=0 → state=0 next edge.
3. Fuel:
   - In DRIVE, fuel_level=3 → state=3 next edge.
   - fuel_level=4 → state=0.
   - In IDLE with fuel_level=2, start → state=3.
   - Same edge with arr_det=1 and fuel_level=0 in DRIVE → state=2.
4. Hysteresis: cpu_temp sequence 80, 90, 85, 76, 75, 89 → shut_off_computer 0, 1, 1, 1, 0, 0, each one edge later. keep_driving stays unchanged throughout.
5. HOLD_CYC=1 build: single-cycle arrived=1 in DRIVE → state=2 after that edge.
6. With ALIF_OVERHEAT_CNT_EN: toggle cpu_temp 95/70 for 300 cycles each way → overheat_cnt=255 and holds. Build without the macro elaborates with no overheat_cnt port.

Source files
------------

// File: rtl/alif_drive_ctrl.sv
// ---------------------------------------------------------------------------
// alif_drive_ctrl
//
// Trip controller placed between the sensor front-end and the vehicle /
// computer power control. Combines:
//   - a hysteretic CPU over-temperature shut-off flag,
//   - a debounced "arrived" detector,
//   - a fuel-empty compare,
//   - a 4-state trip FSM (IDLE, DRIVE, ARRIVED, STALLED) whose DRIVE state
//     is presented on a registered keep_driving output.
//
// Parameters
//   TEMP_W    width of cpu_temp
//   TEMP_HI   shut-off threshold (cpu_temp >= TEMP_HI sets the flag)
//   TEMP_LO   restore threshold (cpu_temp <= TEMP_LO clears the flag),
//             must be below TEMP_HI
//   FUEL_W    width of fuel_level
//   FUEL_MIN  tank is empty when fuel_level < FUEL_MIN
//   HOLD_CYC  consecutive high samples of arrived needed (>= 1, 1 = none)
//
// Ports
//   clk                in   rising-edge clock
//   rst_n              in   asynchronous active-low reset
//   start              in   trip request
//   arrived            in   raw destination-reached indication
//   cpu_temp           in   unsigned CPU temperature
//   fuel_level         in   unsigned fuel level
//   shut_off_computer  out  registered hysteretic overheat flag
//   keep_driving       out  registered, high only in DRIVE
//   state              out  FSM state (0 IDLE, 1 DRIVE, 2 ARRIVED, 3 STALLED)
//   overheat_cnt       out  saturating count of shut-off rising edges,
//                           present only when ALIF_OVERHEAT_CNT_EN is defined
//
// Optional build macro: ALIF_OVERHEAT_CNT_EN
// ---------------------------------------------------------------------------
module alif_drive_ctrl #(
    parameter int TEMP_W   = 8,
    parameter int TEMP_HI  = 90,
    parameter int TEMP_LO  = 75,
    parameter int FUEL_W   = 8,
    parameter int FUEL_MIN = 4,
    parameter int HOLD_CYC = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              arrived,
    input  logic [TEMP_W-1:0] cpu_temp,
    input  logic [FUEL_W-1:0] fuel_level,
    output logic              shut_off_computer,
    output logic              keep_driving,
    output logic [1:0]        state
`ifdef ALIF_OVERHEAT_CNT_EN
    ,
    output logic [7:0]        overheat_cnt
`endif
);

    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    localparam logic [TEMP_W-1:0] T_HI    = TEMP_W'(TEMP_HI);
    localparam logic [TEMP_W-1:0] T_LO    = TEMP_W'(TEMP_LO);
    localparam logic [FUEL_W-1:0] F_MIN   = FUEL_W'(FUEL_MIN);
    localparam logic [CNT_W-1:0]  ARR_MAX = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        ARRIVED = 2'd2,
        STALLED = 2'd3
    } state_t;

    // Debounce counter step: cleared by a low sample, otherwise counts up
    // and parks at HOLD_CYC-1 so arr_det stays asserted while arrived holds.
    function automatic logic [CNT_W-1:0] arr_cnt_step(
        input logic             arr,
        input logic [CNT_W-1:0] cnt
    );
        if (!arr)
            return '0;
        else if (cnt == ARR_MAX)
            return cnt;
        else
            return cnt + CNT_W'(1);
    endfunction

`ifdef ALIF_OVERHEAT_CNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction
`endif

    state_t             state_r;
    state_t             state_nxt;
    logic [CNT_W-1:0]   arr_cnt;
    logic               arr_det;
    logic               empty;
    logic               shut_nxt;

    assign arr_det = arrived && (arr_cnt == ARR_MAX);
    assign empty   = fuel_level < F_MIN;
    assign state   = state_r;

    // Hysteresis: between the two thresholds the flag keeps its value.
    always_comb begin
        shut_nxt = shut_off_computer;
        if (cpu_temp >= T_HI)
            shut_nxt = 1'b1;
        else if (cpu_temp <= T_LO)
            shut_nxt = 1'b0;
    end

    // Arrival wins over running dry while driving; a refuelled stall always
    // returns to IDLE so a fresh start is needed to drive again.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (start)
                    state_nxt = empty ? STALLED : DRIVE;
            end
            DRIVE: begin
                if (arr_det)
                    state_nxt = ARRIVED;
                else if (empty)
                    state_nxt = STALLED;
            end
            ARRIVED: begin
                if (!arrived)
                    state_nxt = IDLE;
            end
            STALLED: begin
                if (!empty)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // --- register stage: FSM, debounce, output flags ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= IDLE;
            arr_cnt           <= '0;
            shut_off_computer <= 1'b0;
            keep_driving      <= 1'b0;
        end else begin
            state_r           <= state_nxt;
            arr_cnt           <= arr_cnt_step(arrived, arr_cnt);
            shut_off_computer <= shut_nxt;
            keep_driving      <= (state_nxt == DRIVE);
        end
    end

`ifdef ALIF_OVERHEAT_CNT_EN
    // Counts on the same edge that raises shut_off_computer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overheat_cnt <= 8'd0;
        else if (shut_nxt && !shut_off_computer)
            overheat_cnt <= sat_inc8(overheat_cnt);
    end
`endif

endmodule
